// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipe_pkg;

    localparam int RA_W_DEF = 5;
    // Scoreboard rd field is sized for the widest supported register file.
    localparam int RA_W_MAX = 8;

    localparam logic [2:0] FWD_RF  = 3'd0;
    localparam logic [2:0] FWD_EX  = 3'd1;
    localparam logic [2:0] FWD_MEM = 3'd2;
    localparam logic [2:0] FWD_WB  = 3'd3;

    typedef struct packed {
        logic                v;
        logic [RA_W_MAX-1:0] rd;
        logic                ld;
    } sb_entry_t;

    function automatic logic [2:0] fwd_sel(input int k);
        return 3'(k + 1);
    endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// Shift register of in-flight destinations (entry 0 = EX, NSTAGE-1 = WB)
// and per-entry source-match vectors for the ID instruction.
module hazard_scoreboard
    import pipe_pkg::*;
#(
    parameter int NSTAGE = 3,
    parameter int RA_W   = RA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push_v,
    input  logic [RA_W-1:0]   push_rd,
    input  logic              push_ld,
    input  logic [RA_W-1:0]   rs1,
    input  logic              rs1_used,
    input  logic [RA_W-1:0]   rs2,
    input  logic              rs2_used,
    output logic [NSTAGE-1:0] match_a,
    output logic [NSTAGE-1:0] match_b,
    output logic              head_ld
);

    sb_entry_t sb [NSTAGE];

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int k = 0; k < NSTAGE; k++) begin
                sb[k] <= '0;
            end
        end else begin
            sb[0].v  <= push_v;
            sb[0].rd <= RA_W_MAX'(push_rd);
            sb[0].ld <= push_ld;
            for (int k = 1; k < NSTAGE; k++) begin
                sb[k] <= sb[k-1];
            end
        end
    end

    // Register 0 is hardwired, so it never produces a hazard.
    always_comb begin
        match_a = '0;
        match_b = '0;
        for (int k = 0; k < NSTAGE; k++) begin
            match_a[k] = rs1_used && (rs1 != '0) && sb[k].v
                         && (sb[k].rd == RA_W_MAX'(rs1));
            match_b[k] = rs2_used && (rs2 != '0) && sb[k].v
                         && (sb[k].rd == RA_W_MAX'(rs2));
        end
    end

    assign head_ld = sb[0].ld;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline interlock, flush and forwarding-select controller.
// Build option: PIPE_HAZARD_FORWARD_EN enables EX operand forwarding.
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int NSTAGE    = 3,
    parameter int RA_W      = RA_W_DEF,
    parameter int FLUSH_CYC = 2,
    parameter int CNT_W     = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [RA_W-1:0]  id_rs1,
    input  logic [RA_W-1:0]  id_rs2,
    input  logic             id_rs1_used,
    input  logic             id_rs2_used,
    input  logic [RA_W-1:0]  id_rd,
    input  logic             id_rd_we,
    input  logic             id_is_load,
    input  logic             ex_branch_taken,
    output logic             stall,
    output logic             issue,
    output logic             flush,
    output logic [2:0]       fwd_a,
    output logic [2:0]       fwd_b,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam logic [2:0] FCNT_LOAD = 3'(FLUSH_CYC - 1);

    logic [NSTAGE-1:0] match_a;
    logic [NSTAGE-1:0] match_b;
    logic              head_ld;
    logic [2:0]        fcnt;
    logic [CNT_W-1:0]  cnt_q;
    logic              flush_c;
    logic              hazard_c;
    logic              stall_c;
    logic              issue_c;
    logic [2:0]        fwd_a_c;
    logic [2:0]        fwd_b_c;

    hazard_scoreboard #(
        .NSTAGE (NSTAGE),
        .RA_W   (RA_W)
    ) u_sb (
        .clk      (clk),
        .rst      (rst),
        .push_v   (issue_c & id_rd_we & (id_rd != '0)),
        .push_rd  (id_rd),
        .push_ld  (id_is_load),
        .rs1      (id_rs1),
        .rs1_used (id_rs1_used),
        .rs2      (id_rs2),
        .rs2_used (id_rs2_used),
        .match_a  (match_a),
        .match_b  (match_b),
        .head_ld  (head_ld)
    );

`ifdef PIPE_HAZARD_FORWARD_EN
    // Only a load still in EX cannot be forwarded in time.
    assign hazard_c = id_valid & (match_a[0] | match_b[0]) & head_ld;

    // Youngest producer wins: lowest matching entry has priority.
    always_comb begin
        fwd_a_c = FWD_RF;
        fwd_b_c = FWD_RF;
        for (int k = NSTAGE - 1; k >= 0; k--) begin
            if (match_a[k]) fwd_a_c = fwd_sel(k);
            if (match_b[k]) fwd_b_c = fwd_sel(k);
        end
    end
`else
    // WB entry is excluded: the regfile writes before it is read.
    localparam logic [NSTAGE-1:0] INTERLOCK_MASK = {1'b0, {(NSTAGE-1){1'b1}}};
    logic unused_head_ld;

    assign hazard_c       = id_valid & (|((match_a | match_b) & INTERLOCK_MASK));
    assign fwd_a_c        = FWD_RF;
    assign fwd_b_c        = FWD_RF;
    assign unused_head_ld = head_ld;
`endif

    assign flush_c = ex_branch_taken | (fcnt != '0);
    assign stall_c = hazard_c & ~flush_c;
    assign issue_c = id_valid & ~stall_c & ~flush_c;

    always_ff @(posedge clk) begin
        if (!rst) begin
            fcnt <= '0;
        end else if (ex_branch_taken) begin
            fcnt <= FCNT_LOAD;
        end else if (fcnt != '0) begin
            fcnt <= fcnt - 3'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (stall_c && (cnt_q != '1)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // Reset gates every output, including the combinational ones.
    assign stall     = rst & stall_c;
    assign issue     = rst & issue_c;
    assign flush     = rst & flush_c;
    assign fwd_a     = rst ? fwd_a_c : FWD_RF;
    assign fwd_b     = rst ? fwd_b_c : FWD_RF;
    assign stall_cnt = rst ? cnt_q : '0;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed scenarios plus random traffic vs a queue model.
module tb_pipe_hazard_ctrl;

    localparam int NSTAGE    = 3;
    localparam int RA_W      = 5;
    localparam int FLUSH_CYC = 2;
    localparam int CNT_W     = 4;
`ifdef PIPE_HAZARD_FORWARD_EN
    localparam bit FWD_ON = 1'b1;
`else
    localparam bit FWD_ON = 1'b0;
`endif

    logic             clk;
    logic             rst;
    logic             id_valid;
    logic [RA_W-1:0]  id_rs1;
    logic [RA_W-1:0]  id_rs2;
    logic             id_rs1_used;
    logic             id_rs2_used;
    logic [RA_W-1:0]  id_rd;
    logic             id_rd_we;
    logic             id_is_load;
    logic             ex_branch_taken;
    logic             stall;
    logic             issue;
    logic             flush;
    logic [2:0]       fwd_a;
    logic [2:0]       fwd_b;
    logic [CNT_W-1:0] stall_cnt;

    pipe_hazard_ctrl #(
        .NSTAGE    (NSTAGE),
        .RA_W      (RA_W),
        .FLUSH_CYC (FLUSH_CYC),
        .CNT_W     (CNT_W)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .id_valid        (id_valid),
        .id_rs1          (id_rs1),
        .id_rs2          (id_rs2),
        .id_rs1_used     (id_rs1_used),
        .id_rs2_used     (id_rs2_used),
        .id_rd           (id_rd),
        .id_rd_we        (id_rd_we),
        .id_is_load      (id_is_load),
        .ex_branch_taken (ex_branch_taken),
        .stall           (stall),
        .issue           (issue),
        .flush           (flush),
        .fwd_a           (fwd_a),
        .fwd_b           (fwd_b),
        .stall_cnt       (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: list of in-flight producers, youngest first.
    typedef struct {
        bit v;
        int rd;
        bit ld;
    } prod_t;

    prod_t q[$];
    int    fl_left;
    int    scnt;
    bit    e_stall, e_issue, e_flush;
    int    e_fwd_a, e_fwd_b, e_cnt;
    int    chk_cnt = 0;
    int    pass_cnt = 0;

    function automatic bit hit(int src, bit used, int k);
        return used && src != 0 && q[k].v && q[k].rd == src;
    endfunction

    function automatic logic [12:0] exp_vec();
        return {e_stall, e_issue, e_flush, 3'(e_fwd_a), 3'(e_fwd_b), CNT_W'(e_cnt)};
    endfunction

    task automatic drive(input bit v, input int r1, input bit u1, input int r2, input bit u2,
                         input int rd, input bit we, input bit ld, input bit br);
        id_valid        = v;
        id_rs1          = r1[RA_W-1:0];
        id_rs1_used     = u1;
        id_rs2          = r2[RA_W-1:0];
        id_rs2_used     = u2;
        id_rd           = rd[RA_W-1:0];
        id_rd_we        = we;
        id_is_load      = ld;
        ex_branch_taken = br;
    endtask

    task automatic settle();
        bit hz;
        int s1, s2;
        #1;
        s1 = int'(id_rs1);
        s2 = int'(id_rs2);
        e_flush = ex_branch_taken || fl_left > 0;
        hz = 1'b0;
        e_fwd_a = 0;
        e_fwd_b = 0;
        if (FWD_ON) begin
            hz = id_valid && (hit(s1, id_rs1_used, 0) || hit(s2, id_rs2_used, 0)) && q[0].ld;
            for (int k = 0; k < NSTAGE; k++) begin
                if (e_fwd_a == 0 && hit(s1, id_rs1_used, k)) e_fwd_a = k + 1;
                if (e_fwd_b == 0 && hit(s2, id_rs2_used, k)) e_fwd_b = k + 1;
            end
        end else begin
            for (int k = 0; k < NSTAGE - 1; k++) begin
                if (hit(s1, id_rs1_used, k) || hit(s2, id_rs2_used, k)) hz = id_valid;
            end
        end
        e_stall = hz && !e_flush;
        e_issue = id_valid && !e_stall && !e_flush;
        e_cnt   = scnt;
        if (!rst) begin
            e_stall = 0; e_issue = 0; e_flush = 0;
            e_fwd_a = 0; e_fwd_b = 0; e_cnt = 0;
        end
    endtask

    task automatic tick();
        prod_t p;
        @(posedge clk);
        if (!rst) begin
            foreach (q[k]) q[k].v = 1'b0;
            fl_left = 0;
            scnt    = 0;
        end else begin
            p.v  = e_issue && id_rd_we && id_rd != 0;
            p.rd = int'(id_rd);
            p.ld = id_is_load;
            q.push_front(p);
            void'(q.pop_back());
            fl_left = ex_branch_taken ? FLUSH_CYC - 1 : (fl_left > 0 ? fl_left - 1 : 0);
            if (e_stall && scnt < (1 << CNT_W) - 1) scnt++;
        end
        @(negedge clk);
    endtask

    task automatic reset_dut();
        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        settle();
        tick();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        drive(1, 3, 1, 3, 1, 3, 1, 1, 1);
        settle();
        chk_cnt++;
        if ({stall, issue, flush, fwd_a, fwd_b, stall_cnt} !== 13'd0)
            $display("FAIL reset_outs: got %h want 0", {stall, issue, flush, fwd_a, fwd_b, stall_cnt});
        else pass_cnt++;
        tick();
        rst = 1'b1;
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        settle();
        chk_cnt++;
        if ({stall, issue, flush, fwd_a, fwd_b, stall_cnt} !== {3'b010, 10'd0})
            $display("FAIL first_cycle: got %h want %h",
                     {stall, issue, flush, fwd_a, fwd_b, stall_cnt}, {3'b010, 10'd0});
        else pass_cnt++;
        tick();
    endtask

    task automatic test_forward();
        reset_dut();
        drive(1, 0, 0, 0, 0, 3, 1, 0, 0);
        settle();
        chk_cnt++;
        if (issue !== 1'b1) $display("FAIL fw_issue: got %b want 1", issue);
        else pass_cnt++;
        tick();
        drive(1, 3, 1, 1, 1, 4, 1, 0, 0);
        settle();
        chk_cnt++;
        if ({stall, fwd_a} !== {!FWD_ON, (FWD_ON ? 3'd1 : 3'd0)})
            $display("FAIL fw_ex: got stall=%b fwd_a=%0d want stall=%b fwd_a=%0d",
                     stall, fwd_a, !FWD_ON, FWD_ON ? 1 : 0);
        else pass_cnt++;
        tick();
        drive(1, 3, 1, 0, 0, 7, 1, 0, 0);
        settle();
        chk_cnt++;
        if ({stall, fwd_a} !== {!FWD_ON, (FWD_ON ? 3'd2 : 3'd0)})
            $display("FAIL fw_mem: got stall=%b fwd_a=%0d want stall=%b fwd_a=%0d",
                     stall, fwd_a, !FWD_ON, FWD_ON ? 2 : 0);
        else pass_cnt++;
        tick();
    endtask

    task automatic test_load_use();
        reset_dut();
        drive(1, 0, 0, 0, 0, 5, 1, 1, 0);
        settle();
        tick();
        drive(1, 5, 1, 1, 1, 6, 1, 0, 0);
        settle();
        chk_cnt++;
        if ({stall, issue} !== 2'b10) $display("FAIL lu_stall: got stall=%b issue=%b want 1 0", stall, issue);
        else pass_cnt++;
        tick();
        settle();
        chk_cnt++;
        if ({stall, fwd_a, stall_cnt} !== {!FWD_ON, (FWD_ON ? 3'd2 : 3'd0), 4'd1})
            $display("FAIL lu_second: got stall=%b fwd_a=%0d cnt=%0d want stall=%b fwd_a=%0d cnt=1",
                     stall, fwd_a, stall_cnt, !FWD_ON, FWD_ON ? 2 : 0);
        else pass_cnt++;
        tick();
        settle();
        chk_cnt++;
        if ({stall, stall_cnt} !== {1'b0, (FWD_ON ? 4'd1 : 4'd2)})
            $display("FAIL lu_release: got stall=%b cnt=%0d want stall=0 cnt=%0d",
                     stall, stall_cnt, FWD_ON ? 1 : 2);
        else pass_cnt++;
        tick();
    endtask

    task automatic test_r0();
        reset_dut();
        drive(1, 0, 0, 0, 0, 0, 1, 1, 0);
        settle();
        tick();
        drive(1, 0, 1, 0, 1, 2, 1, 0, 0);
        settle();
        chk_cnt++;
        if ({stall, issue, fwd_a, fwd_b} !== {2'b01, 6'd0})
            $display("FAIL r0_nohaz: got stall=%b issue=%b fwd_a=%0d fwd_b=%0d want 0 1 0 0",
                     stall, issue, fwd_a, fwd_b);
        else pass_cnt++;
        tick();
    endtask

    task automatic test_branch_flush();
        reset_dut();
        drive(1, 0, 0, 0, 0, 5, 1, 1, 0);
        settle();
        tick();
        drive(1, 5, 1, 0, 0, 6, 1, 0, 1);
        settle();
        chk_cnt++;
        if ({stall, issue, flush} !== 3'b001)
            $display("FAIL br_beats_stall: got %b want 001", {stall, issue, flush});
        else pass_cnt++;
        tick();
        drive(1, 5, 1, 0, 0, 6, 1, 0, 1);
        settle();
        chk_cnt++;
        if ({stall, issue, flush} !== 3'b001)
            $display("FAIL br_cycle2: got %b want 001", {stall, issue, flush});
        else pass_cnt++;
        tick();
        drive(1, 5, 1, 0, 0, 6, 1, 0, 0);
        settle();
        chk_cnt++;
        if ({stall, issue, flush} !== 3'b001)
            $display("FAIL br_extend: got %b want 001", {stall, issue, flush});
        else pass_cnt++;
        tick();
        settle();
        chk_cnt++;
        if ({stall, issue, flush} !== 3'b010)
            $display("FAIL br_end: got %b want 010", {stall, issue, flush});
        else pass_cnt++;
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
        settle();
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        settle();
        chk_cnt++;
        if (flush !== 1'b1) $display("FAIL br_single_hold: got %b want 1", flush);
        else pass_cnt++;
        tick();
        settle();
        chk_cnt++;
        if (flush !== 1'b0) $display("FAIL br_single_end: got %b want 0", flush);
        else pass_cnt++;
        tick();
    endtask

    task automatic test_reset_mid_stall();
        reset_dut();
        drive(1, 0, 0, 0, 0, 1, 1, 0, 0);
        settle();
        tick();
        drive(1, 0, 0, 0, 0, 2, 1, 0, 0);
        settle();
        tick();
        drive(1, 0, 0, 0, 0, 3, 1, 1, 0);
        settle();
        tick();
        drive(1, 3, 1, 0, 0, 4, 1, 0, 0);
        settle();
        chk_cnt++;
        if (stall !== 1'b1) $display("FAIL rms_stall: got %b want 1", stall);
        else pass_cnt++;
        tick();
        rst = 1'b0;
        settle();
        chk_cnt++;
        if ({stall, issue, flush, fwd_a, fwd_b, stall_cnt} !== 13'd0)
            $display("FAIL rms_forced: got %h want 0", {stall, issue, flush, fwd_a, fwd_b, stall_cnt});
        else pass_cnt++;
        tick();
        rst = 1'b1;
        settle();
        chk_cnt++;
        if ({stall, issue, fwd_a, stall_cnt} !== {2'b01, 3'd0, 4'd0})
            $display("FAIL rms_no_stale: got stall=%b issue=%b fwd_a=%0d cnt=%0d want 0 1 0 0",
                     stall, issue, fwd_a, stall_cnt);
        else pass_cnt++;
        tick();
    endtask

    task automatic test_saturation();
        reset_dut();
        for (int i = 0; i < 60; i++) begin
            if (i % 3 == 0) drive(1, 0, 0, 0, 0, 5, 1, 1, 0);
            else            drive(1, 5, 1, 0, 0, 6, 1, 0, 0);
            settle();
            chk_cnt++;
            if ({stall, issue, flush, fwd_a, fwd_b, stall_cnt} !== exp_vec())
                $display("FAIL sat_model cyc %0d: got %h want %h", i,
                         {stall, issue, flush, fwd_a, fwd_b, stall_cnt}, exp_vec());
            else pass_cnt++;
            tick();
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        settle();
        chk_cnt++;
        if (stall_cnt !== 4'hF) $display("FAIL sat_value: got %0d want 15", stall_cnt);
        else pass_cnt++;
        tick();
    endtask

    task automatic test_random();
        reset_dut();
        for (int i = 0; i < 500; i++) begin
            rst = ($urandom_range(0, 63) != 0);
            drive($urandom_range(0, 9) != 0,
                  $urandom_range(0, 3), $urandom_range(0, 1),
                  $urandom_range(0, 3), $urandom_range(0, 1),
                  $urandom_range(0, 3), $urandom_range(0, 3) != 0,
                  $urandom_range(0, 2) == 0, $urandom_range(0, 15) == 0);
            settle();
            chk_cnt++;
            if ({stall, issue, flush, fwd_a, fwd_b, stall_cnt} !== exp_vec())
                $display("FAIL rand cyc %0d: got %h want %h", i,
                         {stall, issue, flush, fwd_a, fwd_b, stall_cnt}, exp_vec());
            else pass_cnt++;
            tick();
        end
        rst = 1'b1;
    endtask

    initial begin
        prod_t b;
        b.v = 1'b0; b.rd = 0; b.ld = 1'b0;
        for (int k = 0; k < NSTAGE; k++) q.push_back(b);
        fl_left = 0;
        scnt    = 0;
        rst     = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        test_reset();
        test_forward();
        test_load_use();
        test_r0();
        test_branch_flush();
        test_reset_mid_stall();
        test_saturation();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Parametrised pipeline interlock and forwarding controller for the 5-stage R/I/J CPU. It replaces the single-cycle IF/ID comparator with a registered scoreboard that tracks every in-flight destination register from EX to WB. It produces stall, bubble, flush and per-operand forwarding selects. It sits beside the ID stage and drives the IF clock-enable, the ID bubble mux and the EX operand muxes.

## Interface
- NSTAGE, 3, scoreboard entries behind ID (index 0 = EX … NSTAGE-1 = WB); legal 2..6
- RA_W, 5, register-address width
- FLUSH_CYC, 2, cycles the front end is killed after a taken branch; legal 1..4
- CNT_W, 32, stall performance-counter width
- clk  in  1  clock; all state updates on posedge
- rst  in  1  synchronous, active-low reset
- id_valid  in  1  ID holds a real instruction
- id_rs1, id_rs2  in  RA_W  source registers of ID instruction
- id_rs1_used, id_rs2_used  in  1  source actually read
- id_rd  in  RA_W  destination of ID instruction
- id_rd_we  in  1  ID instruction writes id_rd
- id_is_load  in  1  ID instruction is a load
- ex_branch_taken  in  1  branch/jump in EX resolved taken
- stall  out  1  hold PC and IF/ID register
- issue  out  1  ID instruction advances into EX this cycle
- flush  out  1  kill IF and ID contents
- fwd_a, fwd_b  out  3  operand source: 0 = regfile, k = scoreboard entry k-1
- stall_cnt  out  CNT_W  saturating count of stall cycles

## Operation
- Scoreboard entry = {v, rd, ld}. Each cycle, entries shift toward WB, and entry NSTAGE-1 retires. Entry 0 loads {issue & id_rd_we & (id_rd≠0), id_rd, id_is_load}; otherwise it loads a bubble (v=0).
- Match(src, k): src used, src≠0, entry k valid, entry k rd = src. Register 0 never hazards.
- With FORWARD_EN: stall = id_valid & (Match(rs1,0)|Match(rs2,0)) & entry0.ld. fwd_x = 1 + lowest k with Match(src_x,k), else 0. The youngest producer wins.
- Without FORWARD_EN: stall = id_valid & any Match over k = 0..NSTAGE-2. The WB-stage match is covered by write-before-read regfile timing. fwd_a = fwd_b = 0.
- Flush: ex_branch_taken asserts flush in the same cycle and loads down-counter fcnt = FLUSH_CYC-1. flush stays high while fcnt≠0; fcnt decrements each cycle.
- While flush is high: stall = 0 and issue = 0. Branch beats stall.
- issue = id_valid & ~stall & ~flush.
- stall_cnt increments on every cycle with stall=1 and saturates at all-ones.

## Timing
- stall, issue, flush and fwd_* are combinational from the current state and inputs, so they are valid in the same cycle. The scoreboard and fcnt are registered.
- Load-use costs exactly 1 bubble with FORWARD_EN. Without it, a dependent instruction stalls until its producer reaches WB (up to NSTAGE-1 cycles).
- ex_branch_taken during a flush window restarts fcnt at FLUSH_CYC-1.
- rst=0 at a posedge clears all entries to v=0, sets fcnt=0 and stall_cnt=0. While rst=0, all outputs are forced to 0. The first post-reset cycle shows stall=0, flush=0, fwd=0, and issue=id_valid.
- A stall inserts a bubble into entry 0 while older entries keep shifting, so the pipeline drains naturally.

## Configuration
- PIPE_HAZARD_FORWARD_EN defined: forwarding logic and load-use-only stalls are built.
- Undefined: no comparator-to-mux priority logic, full interlock stalls apply, and fwd_* are tied to 0. The ports remain so the CPU top is unchanged.

## Structure
- Shared package pipe_pkg holds sb_entry_t (v, rd, ld), the fwd-select encoding constants (FWD_RF = 0, FWD_EX = 1, FWD_MEM = 2, FWD_WB = 3) and the RA_W default.
- One sub-module, hazard_scoreboard, holds the NSTAGE shift register and per-entry match vectors. The top holds the stall/flush logic, fcnt and stall_cnt.

## Test plan
- ADD r3 issued, next ADD reads r3 (FORWARD_EN) -> no stall, fwd_a=1. One cycle later a reader of r3 sees fwd_a=2.
- LW r5 then ADD r6,r5,r1 -> stall=1 for exactly 1 cycle, issue=0, then fwd_a=2. stall_cnt=1.
- Same LW/ADD sequence without FORWARD_EN and NSTAGE=3 -> stall for 2 cycles, fwd_a=0.
- ADD r0 then reader of r0 -> no stall, fwd=0.
- ex_branch_taken pulse while ID stalls on a load-use -> flush=1 for 2 cycles, stall=0, issue=0. A second pulse in cycle 2 extends flush to cycle 3.
- rst=0 mid-stall with 3 valid entries -> next cycle all outputs 0. After release, no stale hazard on r3; stall_cnt is held at 0 during reset.
